// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock, start/busy/done handshake.
// Produces quotient and remainder WIDTH+2 cycles apart when start is held high.
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t           state_r;
  logic [CW-1:0]    count_r;
  logic [WIDTH-1:0] qreg_r;
  logic [WIDTH-1:0] divisor_r;
  // The settled remainder is always below the divisor, so only the shifted
  // value needs the extra bit for the WIDTH+1-bit compare/subtract.
  logic [WIDTH-1:0] rem_r;
  logic [WIDTH:0]   rem_shift_s;
  logic [WIDTH-1:0] rem_next_s;
  logic [WIDTH-1:0] qreg_next_s;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    rem_shift_s = {rem_r, qreg_r[WIDTH-1]};
    qreg_next_s = {qreg_r[WIDTH-2:0], 1'b0};
    rem_next_s  = rem_shift_s[WIDTH-1:0];
    if (rem_shift_s >= {1'b0, divisor_r}) begin
      rem_next_s     = WIDTH'(rem_shift_s - {1'b0, divisor_r});
      qreg_next_s[0] = 1'b1;
    end else begin
      rem_next_s     = rem_shift_s[WIDTH-1:0];
      qreg_next_s[0] = 1'b0;
    end
  end

  // Control FSM, datapath registers and registered handshake/result outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      count_r   <= {CW{1'b0}};
      qreg_r    <= {WIDTH{1'b0}};
      divisor_r <= {WIDTH{1'b0}};
      rem_r     <= {WIDTH{1'b0}};
      busy      <= 1'b0;
      done      <= 1'b0;
      q         <= {WIDTH{1'b0}};
      r         <= {WIDTH{1'b0}};
      div_zero  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          busy <= 1'b0;
          done <= 1'b0;
          if (start) begin
            if (b == {WIDTH{1'b0}}) begin
              q        <= {WIDTH{1'b1}};
              r        <= a;
              div_zero <= 1'b1;
              done     <= 1'b1;
              state_r  <= FIN;
            end else begin
              qreg_r    <= a;
              divisor_r <= b;
              rem_r     <= {WIDTH{1'b0}};
              count_r   <= CW'(WIDTH);
              busy      <= 1'b1;
              state_r   <= RUN;
            end
          end
        end
        RUN: begin
          qreg_r  <= qreg_next_s;
          rem_r   <= rem_next_s;
          count_r <= count_r - CW'(1);
          if (count_r == CW'(1)) begin
            q        <= qreg_next_s;
            r        <= rem_next_s;
            div_zero <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b1;
            state_r  <= FIN;
          end
        end
        FIN: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: scoreboard of expected q/r/div_zero,
// one task per scenario, outputs sampled on the falling clock edge.
module tb_seq_divider;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] q;
  logic [31:0] r;
  logic        div_zero;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  seq_divider #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .q(q), .r(r), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [31:0] ai, input logic [31:0] bi);
    exp_t e;
    e.a = ai;
    e.b = bi;
    if (bi == 32'd0) begin
      e.q  = 32'hFFFF_FFFF;
      e.r  = ai;
      e.dz = 1'b1;
    end else begin
      e.q  = ai / bi;
      e.r  = ai % bi;
      e.dz = 1'b0;
    end
    return e;
  endfunction

  // Drive a request at the current falling edge and record its expected result.
  task automatic issue(input logic [31:0] ai, input logic [31:0] bi);
    a = ai;
    b = bi;
    start = 1'b1;
    sb.push_back(model(ai, bi));
  endtask

  // Called at cycle 1 after acceptance; returns the cycle done was seen.
  task automatic wait_done(input int budget, output int cycles, output int busy_cnt, output bit got);
    cycles = 1;
    busy_cnt = 0;
    got = 1'b0;
    while (!got && cycles <= budget) begin
      if (done === 1'b1) begin
        got = 1'b1;
      end else begin
        if (busy === 1'b1) busy_cnt++;
        @(negedge clk);
        cycles++;
      end
    end
  endtask

  task automatic test_reset;
    n_vec++;
    if ({busy, done, div_zero, q, r} !== 67'd0) begin
      n_bad++;
      $display("FAIL reset_state: got busy=%b done=%b dz=%b q=%h r=%h, want all zero", busy, done, div_zero, q, r);
    end
    reset = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({busy, done} !== 2'b00) begin
      n_bad++;
      $display("FAIL idle_after_reset: got busy=%b done=%b, want 0 0", busy, done);
    end
  endtask

  // Issue one op, check latency/busy length if asked, then compare against the scoreboard.
  task automatic run_one(input string name, input logic [31:0] ai, input logic [31:0] bi,
                         input int exp_cyc, input int exp_busy);
    exp_t e;
    int   cyc, bc;
    bit   got;
    issue(ai, bi);
    @(negedge clk);
    start = 1'b0;
    wait_done(40, cyc, bc, got);
    n_vec++;
    if (!got) begin
      n_bad++;
      $display("FAIL %s_timeout: no done within %0d cycles, want done at cycle %0d", name, cyc - 1, exp_cyc);
    end
    n_vec++;
    if (cyc != exp_cyc || bc != exp_busy) begin
      n_bad++;
      $display("FAIL %s_latency: got done cycle %0d busy %0d, want %0d and %0d", name, cyc, bc, exp_cyc, exp_busy);
    end
    e = sb.pop_front();
    n_vec++;
    if (q !== e.q || r !== e.r || div_zero !== e.dz) begin
      n_bad++;
      $display("FAIL %s_result: got q=%h r=%h dz=%b, want q=%h r=%h dz=%b", name, q, r, div_zero, e.q, e.r, e.dz);
    end
    @(negedge clk);
    n_vec++;
    if (done !== 1'b0 || q !== e.q || r !== e.r || div_zero !== e.dz) begin
      n_bad++;
      $display("FAIL %s_hold: got done=%b q=%h r=%h dz=%b, want done=0 q=%h r=%h dz=%b",
               name, done, q, r, div_zero, e.q, e.r, e.dz);
    end
  endtask

  task automatic test_basic;
    run_one("basic_100_7", 32'd100, 32'd7, 33, 32);
  endtask

  task automatic test_wide;
    run_one("ffff_div_1", 32'hFFFF_FFFF, 32'd1, 33, 32);
    run_one("ffff_div_msb", 32'hFFFF_FFFF, 32'h8000_0000, 33, 32);
    run_one("a_lt_b", 32'd6, 32'd9, 33, 32);
    run_one("a_zero", 32'd0, 32'd17, 33, 32);
  endtask

  task automatic test_div_zero;
    run_one("div_zero", 32'd5, 32'd0, 1, 0);
    run_one("after_div_zero", 32'd9, 32'd3, 33, 32);
  endtask

  task automatic test_ignore_start;
    exp_t e;
    int   n_done = 0;
    int   done_cyc = 0;
    logic [31:0] q_seen = 32'd0;
    logic [31:0] r_seen = 32'd0;
    issue(32'd3, 32'd10);
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (c == 10) begin
        a = 32'd50;
        b = 32'd5;
        start = 1'b1;
      end
      if (c == 11) start = 1'b0;
      if (done === 1'b1) begin
        n_done++;
        done_cyc = c;
        q_seen = q;
        r_seen = r;
      end
    end
    e = sb.pop_front();
    n_vec++;
    if (n_done != 1 || done_cyc != 33) begin
      n_bad++;
      $display("FAIL ignore_start_pulses: got %0d done pulses (last at %0d), want 1 at 33", n_done, done_cyc);
    end
    n_vec++;
    if (q_seen !== e.q || r_seen !== e.r) begin
      n_bad++;
      $display("FAIL ignore_start_result: got q=%h r=%h, want q=%h r=%h", q_seen, r_seen, e.q, e.r);
    end
  endtask

  task automatic test_reset_mid;
    int n_done = 0;
    a = 32'd1000;
    b = 32'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_vec++;
    if ({busy, done, div_zero, q, r} !== 67'd0) begin
      n_bad++;
      $display("FAIL reset_mid_state: got busy=%b done=%b dz=%b q=%h r=%h, want all zero", busy, done, div_zero, q, r);
    end
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) n_done++;
    end
    n_vec++;
    if (n_done != 0) begin
      n_bad++;
      $display("FAIL reset_mid_abandon: got %0d busy/done cycles after reset, want 0", n_done);
    end
    run_one("after_reset_1000_3", 32'd1000, 32'd3, 33, 32);
  endtask

  task automatic test_back_to_back;
    exp_t e;
    logic [31:0] ra, rb;
    int cyc = 0;
    int last = -1;
    int seen = 0;
    ra = $urandom;
    rb = $urandom >> $urandom_range(0, 31);
    if (rb == 32'd0) rb = 32'd1;
    issue(ra, rb);
    while (seen < 10 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (done === 1'b1) begin
        e = sb.pop_front();
        n_vec++;
        if (q !== e.q || r !== e.r || div_zero !== e.dz) begin
          n_bad++;
          $display("FAIL b2b_case%0d: %h/%h got q=%h r=%h dz=%b, want q=%h r=%h dz=0",
                   seen, e.a, e.b, q, r, div_zero, e.q, e.r);
        end else begin
          $display("b2b case %0d PASS: %h / %h = %h rem %h", seen, e.a, e.b, q, r);
        end
        if (last >= 0) begin
          n_vec++;
          if (cyc - last != 34) begin
            n_bad++;
            $display("FAIL b2b_spacing%0d: got %0d cycles between results, want 34", seen, cyc - last);
          end
        end
        last = cyc;
        seen++;
        if (seen < 10) begin
          ra = $urandom;
          rb = $urandom >> $urandom_range(0, 31);
          if (rb == 32'd0) rb = 32'd1;
          issue(ra, rb);
        end else begin
          start = 1'b0;
        end
      end
    end
    n_vec++;
    if (seen != 10) begin
      n_bad++;
      $display("FAIL b2b_count: got %0d results, want 10", seen);
    end
  endtask

  initial begin
    clk = 1'b0;
    reset = 1'b1;
    start = 1'b0;
    a = 32'd0;
    b = 32'd0;
    repeat (3) @(negedge clk);
    test_reset;
    test_basic;
    test_wide;
    test_reset_mid;
    test_div_zero;
    test_ignore_start;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
